// File: rtl/can_pkg.sv
// Shared CAN controller constants and types.
package can_pkg;

    localparam int unsigned CRC15_W = 15;
    localparam logic [CRC15_W-1:0] CRC15_POLY = 15'h4599;
    localparam int unsigned CAN_MAX_BITS = 103;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCrc
    } crc_chk_state_t;

endpackage

// File: rtl/can_crc15_step.sv
// Single-bit serial CRC-15 update; shared by the receive checker and the transmit serial path.
module can_crc15_step
    import can_pkg::*;
#(
    parameter logic [CRC15_W-1:0] POLY = CRC15_POLY
) (
    input  logic [CRC15_W-1:0] crc,
    input  logic               data,
    output logic [CRC15_W-1:0] next_crc
);

    logic fb;

    assign fb       = data ^ crc[CRC15_W-1];
    assign next_crc = {crc[CRC15_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/can_crc15_rx_check.sv
// Receive-side CRC-15 checker: accumulates the frame CRC, captures the received CRC sequence
// and issues a one-cycle verdict or framing-error pulse.
module can_crc15_rx_check
    import can_pkg::*;
#(
    parameter logic [CRC15_W-1:0] INIT     = 15'h0000,
    parameter logic [CRC15_W-1:0] POLY     = CRC15_POLY,
    parameter int unsigned        MAX_BITS = CAN_MAX_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               bit_is_crc,
    output logic [CRC15_W-1:0] crc_calc,
    output logic [CRC15_W-1:0] crc_rx,
    output logic [6:0]         data_bits,
    output logic               busy,
    output logic               check_done,
    output logic               crc_ok,
    output logic               fmt_err
);

    localparam logic [6:0] MaxBits = 7'(MAX_BITS);

    crc_chk_state_t state_q, state_d, state_b;

    logic [CRC15_W-1:0] crc_q, crc_d, crc_base, crc_stepped;
    logic [CRC15_W-1:0] crc_calc_q, crc_calc_d;
    logic [CRC15_W-1:0] crc_rx_q, crc_rx_d, rx_base, rx_shifted;
    logic [6:0]         data_bits_q, data_bits_d, nbits_base;
    logic [3:0]         crc_cnt_q, crc_cnt_d;
    logic               check_done_q, check_done_d;
    logic               crc_ok_q, crc_ok_d;
    logic               fmt_err_q, fmt_err_d;

    // A start in the same cycle as a bit makes that bit step from INIT (SOF handling).
    assign crc_base = frame_start ? INIT : crc_q;

    can_crc15_step #(
        .POLY(POLY)
    ) u_step (
        .crc     (crc_base),
        .data    (bit_in),
        .next_crc(crc_stepped)
    );

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        crc_calc_d   = crc_calc_q;
        crc_rx_d     = crc_rx_q;
        data_bits_d  = data_bits_q;
        crc_cnt_d    = crc_cnt_q;
        check_done_d = 1'b0;
        crc_ok_d     = crc_ok_q;
        fmt_err_d    = 1'b0;
        state_b      = state_q;
        rx_base      = crc_rx_q;
        nbits_base   = data_bits_q;

        if (frame_start) begin
            state_b    = StData;
            rx_base    = '0;
            nbits_base = '0;
        end
        rx_shifted = {rx_base[CRC15_W-2:0], bit_in};

        if (abort) begin
            state_d = StIdle;
        end else begin
            state_d     = state_b;
            crc_d       = crc_base;
            crc_rx_d    = rx_base;
            data_bits_d = nbits_base;
            if (bit_valid) begin
                unique case (state_b)
                    StData: begin
                        if (!bit_is_crc) begin
                            if (nbits_base == MaxBits) begin
                                fmt_err_d = 1'b1;
                                state_d   = StIdle;
                            end else begin
                                crc_d       = crc_stepped;
                                data_bits_d = nbits_base + 7'd1;
                            end
                        end else begin
                            crc_calc_d = crc_base;
                            crc_rx_d   = rx_shifted;
                            crc_cnt_d  = 4'd1;
                            state_d    = StCrc;
                        end
                    end
                    StCrc: begin
                        if (bit_is_crc) begin
                            crc_rx_d = rx_shifted;
                            if (crc_cnt_q == 4'd14) begin
                                check_done_d = 1'b1;
                                crc_ok_d     = (rx_shifted == crc_calc_q);
                                crc_cnt_d    = 4'd0;
                                state_d      = StIdle;
                            end else begin
                                crc_cnt_d = crc_cnt_q + 4'd1;
                            end
                        end else begin
                            fmt_err_d = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            crc_q        <= INIT;
            crc_calc_q   <= '0;
            crc_rx_q     <= '0;
            data_bits_q  <= '0;
            crc_cnt_q    <= '0;
            check_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            fmt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            crc_calc_q   <= crc_calc_d;
            crc_rx_q     <= crc_rx_d;
            data_bits_q  <= data_bits_d;
            crc_cnt_q    <= crc_cnt_d;
            check_done_q <= check_done_d;
            crc_ok_q     <= crc_ok_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign crc_calc   = crc_calc_q;
    assign crc_rx     = crc_rx_q;
    assign data_bits  = data_bits_q;
    assign busy       = (state_q != StIdle);
    assign check_done = check_done_q;
    assign crc_ok     = crc_ok_q;
    assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_can_crc15_rx_check.sv
// Directed bench for can_crc15_rx_check with a polynomial-division reference model.
module tb_can_crc15_rx_check;

    logic        clk = 1'b0;
    logic        rst, frame_start, abort, bit_valid, bit_in, bit_is_crc;
    logic [14:0] crc_calc, crc_rx;
    logic [6:0]  data_bits;
    logic        busy, check_done, crc_ok, fmt_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b1;

    always #5 clk = ~clk;

    can_crc15_rx_check dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_is_crc (bit_is_crc),
        .crc_calc   (crc_calc),
        .crc_rx     (crc_rx),
        .data_bits  (data_bits),
        .busy       (busy),
        .check_done (check_done),
        .crc_ok     (crc_ok),
        .fmt_err    (fmt_err)
    );

    // CRC as the remainder of msg * x^15 divided by the generator (long division, INIT = 0).
    function automatic logic [14:0] crc_of(input logic msg[$]);
        logic [15:0] gen;
        logic        m[$];
        logic [14:0] r;
        int          n;
        gen = 16'hC599;
        m   = msg;
        n   = msg.size();
        for (int k = 0; k < 15; k++) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ gen[15-j];
        for (int k = 0; k < 15; k++) r[14-k] = m[n+k];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the frame, updated from the inputs seen at each rising edge.
    int          m_mode;   // 0 idle, 1 data, 2 crc
    logic        m_dq[$];
    logic [14:0] m_calc, m_rx;
    int          m_nbits, m_ncrc;
    logic        m_done, m_ok, m_fmt;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_dq.delete(); m_calc = '0; m_rx = '0; m_nbits = 0; m_ncrc = 0;
            m_done = 0; m_ok = 0; m_fmt = 0;
        end else begin
            m_done = 0;
            m_fmt  = 0;
            if (abort) m_mode = 0;
            else begin
                if (frame_start) begin
                    m_mode = 1; m_dq.delete(); m_nbits = 0; m_rx = '0;
                end
                if (bit_valid && m_mode == 1) begin
                    if (!bit_is_crc) begin
                        if (m_nbits == 103) begin m_fmt = 1; m_mode = 0; end
                        else begin m_dq.push_back(bit_in); m_nbits++; end
                    end else begin
                        m_calc = crc_of(m_dq);
                        m_rx   = {m_rx[13:0], bit_in};
                        m_ncrc = 1;
                        m_mode = 2;
                    end
                end else if (bit_valid && m_mode == 2) begin
                    if (bit_is_crc) begin
                        m_rx = {m_rx[13:0], bit_in};
                        m_ncrc++;
                        if (m_ncrc == 15) begin m_done = 1; m_ok = (m_rx == m_calc); m_mode = 0; end
                    end else begin
                        m_fmt = 1; m_mode = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model crc_calc", 32'(crc_calc), 32'(m_calc));
            check("model crc_rx", 32'(crc_rx), 32'(m_rx));
            check("model data_bits", 32'(data_bits), 32'(m_nbits));
            check("model busy", 32'(busy), 32'(m_mode != 0));
            check("model check_done", 32'(check_done), 32'(m_done));
            check("model crc_ok", 32'(crc_ok), 32'(m_ok));
            check("model fmt_err", 32'(fmt_err), 32'(m_fmt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic c);
        bit_valid = 1'b1; bit_in = b; bit_is_crc = c;
        tick();
        bit_valid = 1'b0; bit_in = 1'b0; bit_is_crc = 1'b0;
    endtask

    task automatic send_crc(input logic [14:0] v, input int n);
        for (int i = 14; i > 14 - n; i--) send_bit(v[i], 1'b1);
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        logic        q[$];
        logic [14:0] good;

        rst = 1'b1; frame_start = 1'b0; abort = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; bit_is_crc = 1'b0;
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset crc_calc", 32'(crc_calc), 32'd0);
        check("reset check_done", 32'(check_done), 32'd0);
        rst = 1'b0;
        tick();

        q = '{1'b1};
        check("model pin 1", 32'(crc_of(q)), 32'h4599);
        q = '{1'b1, 1'b0};
        check("model pin 10", 32'(crc_of(q)), 32'h4EAB);

        // Minimal frame
        start(); send_bit(1'b1, 1'b0); send_crc(15'h4599, 15);
        check("min check_done", 32'(check_done), 32'd1);
        check("min crc_ok", 32'(crc_ok), 32'd1);
        check("min crc_calc", 32'(crc_calc), 32'h4599);
        check("min data_bits", 32'(data_bits), 32'd1);
        check("min busy", 32'(busy), 32'd0);
        tick();
        check("min done falls", 32'(check_done), 32'd0);
        check("min ok holds", 32'(crc_ok), 32'd1);

        // Two-bit frame, good then bad CRC
        start(); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_crc(15'h4EAB, 15);
        check("two ok", 32'(crc_ok), 32'd1);
        start(); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_crc(15'h4EAA, 15);
        check("two bad done", 32'(check_done), 32'd1);
        check("two bad ok", 32'(crc_ok), 32'd0);
        check("two bad crc_rx", 32'(crc_rx), 32'h4EAA);

        // Zero frame
        start(); repeat (19) send_bit(1'b0, 1'b0); send_crc(15'h0000, 15);
        check("zero ok", 32'(crc_ok), 32'd1);
        check("zero data_bits", 32'(data_bits), 32'd19);

        // CRC field cut short
        start(); send_bit(1'b1, 1'b0); send_crc(15'h4599, 7); send_bit(1'b0, 1'b0);
        check("short fmt_err", 32'(fmt_err), 32'd1);
        check("short no done", 32'(check_done), 32'd0);
        check("short busy", 32'(busy), 32'd0);
        tick();
        check("short fmt falls", 32'(fmt_err), 32'd0);

        // Data field overrun
        start();
        for (int i = 0; i < 103; i++) send_bit(1'((i % 3) == 0), 1'b0);
        check("long 103 no fmt", 32'(fmt_err), 32'd0);
        check("long 103 busy", 32'(busy), 32'd1);
        check("long 103 bits", 32'(data_bits), 32'd103);
        send_bit(1'b1, 1'b0);
        check("long 104 fmt", 32'(fmt_err), 32'd1);
        check("long 104 busy", 32'(busy), 32'd0);

        // Abort mid-DATA
        start(); repeat (5) send_bit(1'b1, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort no fmt", 32'(fmt_err), 32'd0);
        repeat (2) tick();

        // Restart mid-CRC, then a valid frame
        start(); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_crc(15'h1234, 5);
        start(); send_bit(1'b1, 1'b0); send_crc(15'h4599, 15);
        check("restart ok", 32'(crc_ok), 32'd1);
        check("restart bits", 32'(data_bits), 32'd1);

        // Abort beats frame_start
        abort = 1'b1; frame_start = 1'b1; tick(); abort = 1'b0; frame_start = 1'b0;
        check("abort+start busy", 32'(busy), 32'd0);
        send_bit(1'b1, 1'b0);
        check("abort+start idle", 32'(data_bits), 32'd1);

        // Reset mid-CRC
        start(); send_bit(1'b1, 1'b0); send_crc(15'h4599, 5);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst crc_calc", 32'(crc_calc), 32'd0);
        check("rst crc_rx", 32'(crc_rx), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst crc_ok", 32'(crc_ok), 32'd0);

        // Back-to-back 64-bit frames, SOF bit carried with frame_start
        for (int pass = 0; pass < 2; pass++) begin
            q.delete();
            for (int i = 0; i < 64; i++) q.push_back(1'($urandom));
            good = crc_of(q);
            if (pass == 1) good[3] = ~good[3];
            bit_valid = 1'b1; bit_is_crc = 1'b0;
            for (int i = 0; i < 64; i++) begin
                frame_start = (i == 0);
                bit_in = q[i];
                tick();
            end
            frame_start = 1'b0;
            bit_is_crc = 1'b1;
            for (int i = 14; i >= 0; i--) begin
                bit_in = good[i];
                tick();
            end
            bit_valid = 1'b0; bit_is_crc = 1'b0; bit_in = 1'b0;
            check("stream done", 32'(check_done), 32'd1);
            check("stream ok", 32'(crc_ok), 32'(pass == 0));
            check("stream bits", 32'(data_bits), 32'd64);
            tick();
        end

        repeat (2) tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
